// File: rtl/sim_dram_axi_arbiter.sv
// N-to-1 AXI4 arbiter in front of the simulated-DRAM port: round-robin AR/AW, W locked to the
// AW winner, R/B routed back by the master-index ID prefix. Define AXI_ARB_RD_LIMIT_EN to cap reads.
module sim_dram_axi_arbiter #(
  parameter int unsigned N         = 2,
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned DATA_BITS = 64,
  parameter int unsigned ID_BITS   = 4,
  parameter int unsigned MIDX      = $clog2(N),
  parameter int unsigned MAX_RD    = 4,
  localparam int unsigned A  = ID_BITS + 8 + 3 + ADDR_BITS,
  localparam int unsigned W  = DATA_BITS + DATA_BITS / 8 + 1,
  localparam int unsigned RW = ID_BITS + 2 + DATA_BITS + 1,
  localparam int unsigned BW = ID_BITS + 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         s_ar_valid,
  output logic [N-1:0]         s_ar_ready,
  input  logic [N*A-1:0]       s_ar_bits,
  input  logic [N-1:0]         s_aw_valid,
  output logic [N-1:0]         s_aw_ready,
  input  logic [N*A-1:0]       s_aw_bits,
  input  logic [N-1:0]         s_w_valid,
  output logic [N-1:0]         s_w_ready,
  input  logic [N*W-1:0]       s_w_bits,
  output logic [N-1:0]         s_r_valid,
  input  logic [N-1:0]         s_r_ready,
  output logic [RW-1:0]        s_r_bits,
  output logic [N-1:0]         s_b_valid,
  input  logic [N-1:0]         s_b_ready,
  output logic [BW-1:0]        s_b_bits,
  output logic                 m_ar_valid,
  input  logic                 m_ar_ready,
  output logic [A+MIDX-1:0]    m_ar_bits,
  output logic                 m_aw_valid,
  input  logic                 m_aw_ready,
  output logic [A+MIDX-1:0]    m_aw_bits,
  output logic                 m_w_valid,
  input  logic                 m_w_ready,
  output logic [W-1:0]         m_w_bits,
  input  logic                 m_r_valid,
  output logic                 m_r_ready,
  input  logic [RW+MIDX-1:0]   m_r_bits,
  input  logic                 m_b_valid,
  output logic                 m_b_ready,
  input  logic [BW+MIDX-1:0]   m_b_bits
);

  // First requester at or after ptr, wrapping; returns ptr when nobody requests.
  function automatic logic [MIDX-1:0] rr_pick(input logic [N-1:0] req, input logic [MIDX-1:0] ptr);
    logic [MIDX-1:0] pick;
    pick = ptr;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) pick = MIDX'((int'(ptr) + k) % N);
    end
    return pick;
  endfunction

  function automatic logic [MIDX-1:0] rr_next(input logic [MIDX-1:0] g);
    return MIDX'((int'(g) + 1) % N);
  endfunction

  // ---------------- AR channel ----------------
  logic [N-1:0]    ar_allow;
  logic [MIDX-1:0] rr_ar_q, rr_ar_d, ar_gnt_q, ar_gnt_d, ar_gnt;
  logic            ar_hold_q, ar_hold_d, ar_ok, ar_hs;

  always_comb begin
    ar_gnt     = ar_hold_q ? ar_gnt_q : rr_pick(s_ar_valid & ar_allow, rr_ar_q);
    ar_ok      = !reset && (ar_hold_q || ar_allow[ar_gnt]);
    m_ar_valid = ar_ok && s_ar_valid[ar_gnt];
    m_ar_bits  = {ar_gnt, s_ar_bits[ar_gnt*A +: A]};
    s_ar_ready = '0;
    s_ar_ready[ar_gnt] = ar_ok && m_ar_ready;
    ar_hs      = m_ar_valid && m_ar_ready;
  end

  always_comb begin
    rr_ar_d   = rr_ar_q;
    ar_hold_d = ar_hold_q;
    ar_gnt_d  = ar_gnt_q;
    if (ar_hs) begin
      rr_ar_d   = rr_next(ar_gnt);
      ar_hold_d = 1'b0;
    end else if (m_ar_valid) begin
      ar_hold_d = 1'b1;
      ar_gnt_d  = ar_gnt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ar_q   <= '0;
      ar_hold_q <= 1'b0;
      ar_gnt_q  <= '0;
    end else begin
      rr_ar_q   <= rr_ar_d;
      ar_hold_q <= ar_hold_d;
      ar_gnt_q  <= ar_gnt_d;
    end
  end

  // ---------------- AW/W channels ----------------
  typedef enum logic [0:0] {StAwArb, StWData} wr_st_e;

  wr_st_e          wr_st_q, wr_st_d;
  logic [MIDX-1:0] rr_aw_q, rr_aw_d, aw_gnt_q, aw_gnt_d, aw_gnt, w_sel_q, w_sel_d;
  logic            aw_hold_q, aw_hold_d, aw_open, w_open, aw_hs, w_hs;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_st_q   <= StAwArb;
      rr_aw_q   <= '0;
      aw_hold_q <= 1'b0;
      aw_gnt_q  <= '0;
      w_sel_q   <= '0;
    end else begin
      wr_st_q   <= wr_st_d;
      rr_aw_q   <= rr_aw_d;
      aw_hold_q <= aw_hold_d;
      aw_gnt_q  <= aw_gnt_d;
      w_sel_q   <= w_sel_d;
    end
  end

  always_comb begin
    wr_st_d   = wr_st_q;
    rr_aw_d   = rr_aw_q;
    aw_hold_d = aw_hold_q;
    aw_gnt_d  = aw_gnt_q;
    w_sel_d   = w_sel_q;
    unique case (wr_st_q)
      StAwArb: begin
        if (aw_hs) begin
          wr_st_d   = StWData;
          w_sel_d   = aw_gnt;
          rr_aw_d   = rr_next(aw_gnt);
          aw_hold_d = 1'b0;
        end else if (m_aw_valid) begin
          aw_hold_d = 1'b1;
          aw_gnt_d  = aw_gnt;
        end
      end
      StWData: begin
        if (w_hs && m_w_bits[0]) wr_st_d = StAwArb;
      end
    endcase
  end

  always_comb begin
    aw_gnt     = aw_hold_q ? aw_gnt_q : rr_pick(s_aw_valid, rr_aw_q);
    aw_open    = !reset && (wr_st_q == StAwArb);
    m_aw_valid = aw_open && s_aw_valid[aw_gnt];
    m_aw_bits  = {aw_gnt, s_aw_bits[aw_gnt*A +: A]};
    s_aw_ready = '0;
    s_aw_ready[aw_gnt] = aw_open && m_aw_ready;
    aw_hs      = m_aw_valid && m_aw_ready;

    w_open     = !reset && (wr_st_q == StWData);
    m_w_valid  = w_open && s_w_valid[w_sel_q];
    m_w_bits   = s_w_bits[w_sel_q*W +: W];
    s_w_ready  = '0;
    s_w_ready[w_sel_q] = w_open && m_w_ready;
    w_hs       = m_w_valid && m_w_ready;
  end

  // ---------------- R/B response routing ----------------
  logic [MIDX-1:0] r_idx, b_idx;

  // An index with no matching master is swallowed so the memory never stalls on it.
  always_comb begin
    r_idx     = m_r_bits[RW+MIDX-1 -: MIDX];
    s_r_bits  = m_r_bits[RW-1:0];
    s_r_valid = '0;
    m_r_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (r_idx == MIDX'(i)) begin
        s_r_valid[i] = m_r_valid;
        m_r_ready    = s_r_ready[i];
      end
    end
    if (reset) begin
      s_r_valid = '0;
      m_r_ready = 1'b0;
    end
  end

  always_comb begin
    b_idx     = m_b_bits[BW+MIDX-1 -: MIDX];
    s_b_bits  = m_b_bits[BW-1:0];
    s_b_valid = '0;
    m_b_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (b_idx == MIDX'(i)) begin
        s_b_valid[i] = m_b_valid;
        m_b_ready    = s_b_ready[i];
      end
    end
    if (reset) begin
      s_b_valid = '0;
      m_b_ready = 1'b0;
    end
  end

  // ---------------- Outstanding-read limit ----------------
`ifdef AXI_ARB_RD_LIMIT_EN
  localparam int unsigned CW = $clog2(MAX_RD + 1);

  logic [N-1:0][CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [N-1:0]         rd_inc, rd_dec;
  logic                 r_last_hs;

  assign r_last_hs = m_r_valid && m_r_ready && m_r_bits[0];

  always_comb begin
    for (int i = 0; i < N; i++) ar_allow[i] = (rd_cnt_q[i] != CW'(MAX_RD));
  end

  always_comb begin
    rd_inc   = '0;
    rd_dec   = '0;
    rd_cnt_d = rd_cnt_q;
    for (int i = 0; i < N; i++) begin
      rd_inc[i] = ar_hs && (ar_gnt == MIDX'(i));
      rd_dec[i] = r_last_hs && (r_idx == MIDX'(i));
      if (rd_inc[i] && !rd_dec[i]) rd_cnt_d[i] = rd_cnt_q[i] + CW'(1);
      else if (rd_dec[i] && !rd_inc[i]) rd_cnt_d[i] = rd_cnt_q[i] - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) rd_cnt_q <= '0;
    else       rd_cnt_q <= rd_cnt_d;
  end
`else
  logic [31:0] unused_max_rd;
  assign unused_max_rd = MAX_RD;
  assign ar_allow      = '1;
`endif

endmodule

// File: tb/tb_sim_dram_axi_arbiter.sv
// Directed bench for sim_dram_axi_arbiter: AR/AW/W handshakes are checked against scoreboard queues.
module tb_sim_dram_axi_arbiter;
  localparam int unsigned N = 2, ADDR_BITS = 32, DATA_BITS = 64, ID_BITS = 4, MIDX = 1;
  localparam int unsigned MAX_RD = 2;
  localparam int unsigned A  = ID_BITS + 8 + 3 + ADDR_BITS;
  localparam int unsigned AM = A + MIDX;
  localparam int unsigned W  = DATA_BITS + DATA_BITS / 8 + 1;
  localparam int unsigned RW = ID_BITS + 2 + DATA_BITS + 1;
  localparam int unsigned BW = ID_BITS + 2;

  logic clock, reset;
  logic [N-1:0] s_ar_valid, s_ar_ready, s_aw_valid, s_aw_ready, s_w_valid, s_w_ready;
  logic [N-1:0] s_r_valid, s_r_ready, s_b_valid, s_b_ready;
  logic [N*A-1:0] s_ar_bits, s_aw_bits;
  logic [N*W-1:0] s_w_bits;
  logic [RW-1:0] s_r_bits;
  logic [BW-1:0] s_b_bits;
  logic m_ar_valid, m_ar_ready, m_aw_valid, m_aw_ready, m_w_valid, m_w_ready;
  logic m_r_valid, m_r_ready, m_b_valid, m_b_ready;
  logic [AM-1:0] m_ar_bits, m_aw_bits;
  logic [W-1:0] m_w_bits;
  logic [RW+MIDX-1:0] m_r_bits;
  logic [BW+MIDX-1:0] m_b_bits;

  sim_dram_axi_arbiter #(
    .N(N), .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS), .ID_BITS(ID_BITS), .MIDX(MIDX),
    .MAX_RD(MAX_RD)
  ) dut (
    .clock(clock), .reset(reset),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_bits(s_ar_bits),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_bits(s_aw_bits),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_bits(s_w_bits),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_bits(s_r_bits),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_bits(s_b_bits),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_bits(m_ar_bits),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_bits(m_aw_bits),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_bits(m_w_bits),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_bits(m_r_bits),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_bits(m_b_bits)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [AM-1:0] ar_exp_q[$];
  logic [AM-1:0] aw_exp_q[$];
  logic [W-1:0]  w_exp_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [A-1:0] mk_a(input logic [3:0] id, input logic [7:0] len,
                                        input logic [31:0] addr);
    return {id, len, 3'd3, addr};
  endfunction

  function automatic logic [W-1:0] mk_w(input logic [63:0] d, input logic last);
    return {d, 8'hff, last};
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check(tag, {m_ar_valid, s_ar_ready, m_aw_valid, s_aw_ready, m_w_valid, s_w_ready,
                s_r_valid, m_r_ready, s_b_valid, m_b_ready}, '0);
  endtask

  // Downstream handshakes land on the next rising edge; inputs are stable at the falling edge.
  always @(negedge clock) begin
    if (m_ar_valid && m_ar_ready) begin
      check("ar_hs_expected", ar_exp_q.size() != 0, 1);
      if (ar_exp_q.size() != 0) check("ar_bits", m_ar_bits, ar_exp_q.pop_front());
    end
    if (m_aw_valid && m_aw_ready) begin
      check("aw_hs_expected", aw_exp_q.size() != 0, 1);
      if (aw_exp_q.size() != 0) check("aw_bits", m_aw_bits, aw_exp_q.pop_front());
    end
    if (m_w_valid && m_w_ready) begin
      check("w_hs_expected", w_exp_q.size() != 0, 1);
      if (w_exp_q.size() != 0) check("w_bits", m_w_bits, w_exp_q.pop_front());
    end
  end

  logic [A-1:0] a0, a1, aw0, aw1, aw1b;

  initial begin
    a0 = mk_a(4'd3, 8'd0, 32'h100);
    a1 = mk_a(4'd5, 8'd0, 32'h200);
    aw0 = mk_a(4'd2, 8'd3, 32'h1000);
    aw1 = mk_a(4'd6, 8'd3, 32'h2000);
    aw1b = mk_a(4'd7, 8'd0, 32'h3000);
    reset = 1'b1;
    s_ar_bits = {a1, a0};
    s_aw_bits = {aw1, aw0};
    s_w_bits = {mk_w(64'hdead_0000, 1'b1), mk_w(64'hd0, 1'b0)};
    s_ar_valid = 2'b11; s_aw_valid = 2'b11; s_w_valid = 2'b11;
    m_ar_ready = 1'b1; m_aw_ready = 1'b1; m_w_ready = 1'b1;
    m_r_valid = 1'b1; m_b_valid = 1'b1; s_r_ready = 2'b11; s_b_ready = 2'b11;
    m_r_bits = '0; m_b_bits = '0;
    cyc();
    mid();
    check_quiet("reset_outputs");

    // Both masters request AR continuously: grants alternate 0,1,0,1.
    cyc();
    reset = 1'b0; s_aw_valid = 2'b00; s_w_valid = 2'b00; m_r_valid = 1'b0; m_b_valid = 1'b0;
    ar_exp_q.push_back({1'b0, a0}); ar_exp_q.push_back({1'b1, a1});
    ar_exp_q.push_back({1'b0, a0}); ar_exp_q.push_back({1'b1, a1});
    repeat (4) cyc();
    s_ar_valid = 2'b00;
    do_reset();

    // Master 1 held through 3 stalled cycles while master 0 arrives.
    s_ar_valid = 2'b10; m_ar_ready = 1'b0;
    mid();
    check("hold_c1_valid", m_ar_valid, 1);
    check("hold_c1_gnt", m_ar_bits[AM-1], 1);
    cyc(); s_ar_valid = 2'b11;
    mid(); check("hold_c2_gnt", m_ar_bits[AM-1], 1);
    check("hold_c2_ready", s_ar_ready, 2'b00);
    cyc(); mid(); check("hold_c3_gnt", m_ar_bits[AM-1], 1);
    cyc(); m_ar_ready = 1'b1; ar_exp_q.push_back({1'b1, a1});
    mid(); check("hold_c4_ready", s_ar_ready, 2'b10);
    cyc(); s_ar_valid = 2'b01; ar_exp_q.push_back({1'b0, a0});
    mid(); check("after_hold_ready", s_ar_ready, 2'b01);
    cyc(); s_ar_valid = 2'b00;

    // Write lock: master 1 AW waits for master 0's WLAST.
    s_aw_valid = 2'b11; s_w_valid = 2'b11;
    aw_exp_q.push_back({1'b0, aw0});
    mid();
    check("awarb_w_closed", {m_w_valid, s_w_ready}, 3'b000);
    check("aw_ready_m0", s_aw_ready, 2'b01);
    for (int i = 0; i < 4; i++) begin
      cyc();
      s_aw_valid = 2'b10;
      s_w_bits[W-1:0] = mk_w(64'hd0 + 64'(i), i == 3);
      w_exp_q.push_back(mk_w(64'hd0 + 64'(i), i == 3));
      mid();
      check("wdata_aw_blocked", {m_aw_valid, s_aw_ready}, 3'b000);
      check("wdata_w_sel_m0", s_w_ready, 2'b01);
    end
    cyc(); s_w_valid = 2'b00; aw_exp_q.push_back({1'b1, aw1});
    mid(); check("aw_m1_after_last", s_aw_ready, 2'b10);

    // Two beats of master 1's burst, then reset mid-burst.
    for (int i = 0; i < 2; i++) begin
      cyc();
      s_aw_valid = 2'b00; s_w_valid = 2'b10;
      s_w_bits[2*W-1 -: W] = mk_w(64'he0 + 64'(i), 1'b0);
      w_exp_q.push_back(mk_w(64'he0 + 64'(i), 1'b0));
    end
    cyc();
    reset = 1'b1; s_aw_valid = 2'b11; s_ar_valid = 2'b11;
    m_r_valid = 1'b1; m_b_valid = 1'b1; s_r_ready = 2'b11; s_b_ready = 2'b11;
    mid(); check_quiet("midburst_reset");
    cyc();
    reset = 1'b0; s_ar_valid = 2'b00; s_aw_valid = 2'b10; s_w_valid = 2'b00;
    m_r_valid = 1'b0; m_b_valid = 1'b0;
    s_aw_bits[2*A-1 -: A] = aw1b;
    aw_exp_q.push_back({1'b1, aw1b});
    mid(); check("post_reset_aw_m1", s_aw_ready, 2'b10);
    cyc();
    s_aw_valid = 2'b00; s_w_valid = 2'b10;
    s_w_bits[2*W-1 -: W] = mk_w(64'hf0, 1'b1);
    w_exp_q.push_back(mk_w(64'hf0, 1'b1));
    mid(); check("post_reset_w_m1", s_w_ready, 2'b10);
    cyc(); s_w_valid = 2'b00;
    mid(); check("post_burst_awarb", {m_w_valid, s_w_ready}, 3'b000);

    // Response routing by ID prefix.
    cyc();
    m_r_valid = 1'b1; m_r_bits = {1'b1, 4'd5, 2'b01, 64'hcafe, 1'b1}; s_r_ready = 2'b10;
    mid();
    check("r_valid_m1", s_r_valid, 2'b10);
    check("r_bits_id5", s_r_bits, {4'd5, 2'b01, 64'hcafe, 1'b1});
    check("r_ready_m1", m_r_ready, 1);
    cyc(); s_r_ready = 2'b01;
    mid();
    check("r_ready_mirror", m_r_ready, 0);
    check("r_valid_only_m1", s_r_valid, 2'b10);
    cyc(); m_r_bits = {1'b0, 4'd7, 2'b00, 64'h1234, 1'b0};
    mid();
    check("r_valid_m0", s_r_valid, 2'b01);
    check("r_ready_m0", m_r_ready, 1);
    cyc();
    m_r_valid = 1'b0; m_b_valid = 1'b1; m_b_bits = {1'b1, 4'd9, 2'b10}; s_b_ready = 2'b10;
    mid();
    check("b_valid_m1", s_b_valid, 2'b10);
    check("b_bits_id9", s_b_bits, {4'd9, 2'b10});
    check("b_ready_m1", m_b_ready, 1);
    cyc(); m_b_bits = {1'b0, 4'd9, 2'b10};
    mid();
    check("b_valid_m0", s_b_valid, 2'b01);
    check("b_ready_m0", m_b_ready, 0);
    cyc(); m_b_valid = 1'b0;

`ifdef AXI_ARB_RD_LIMIT_EN
    // With MAX_RD=2 the third read from master 0 waits for an R last.
    do_reset();
    s_ar_valid = 2'b01; m_ar_ready = 1'b1;
    ar_exp_q.push_back({1'b0, a0}); ar_exp_q.push_back({1'b0, a0});
    cyc(); cyc();
    mid(); check("rd_cap_block", m_ar_valid, 0);
    cyc();
    m_r_valid = 1'b1; m_r_bits = {1'b0, 4'd3, 2'b00, 64'h0, 1'b1}; s_r_ready = 2'b01;
    mid(); check("rd_cap_block_r", m_ar_valid, 0);
    cyc(); m_r_valid = 1'b0; ar_exp_q.push_back({1'b0, a0});
    mid(); check("rd_cap_release", m_ar_valid, 1);
    cyc(); s_ar_valid = 2'b00;
`endif

    cyc();
    check("ar_sb_drained", ar_exp_q.size(), 0);
    check("aw_sb_drained", aw_exp_q.size(), 0);
    check("w_sb_drained", w_exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
